// File: rtl/hit_readout_pkg.sv
// ============================================================================
//  Module   : hit_readout_pkg
//  Purpose  : Shared widths, derived memory geometry, HCM word field offsets,
//             readout FSM state encoding and the HLM slot-select helper.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package hit_readout_pkg;

  localparam int SSIDBITS         = 12;
  localparam int COLINDEXBITS     = 5;
  localparam int ROWINDEXBITS_HNM = SSIDBITS - COLINDEXBITS;
  localparam int NCOLS_HNM        = 2 ** COLINDEXBITS;
  localparam int NROWS_HNM        = 2 ** ROWINDEXBITS_HNM;

  localparam int HITINFOBITS      = 8;
  localparam int HITSPERROW       = 4;
  localparam int NCOLS_HLM        = HITSPERROW * HITINFOBITS;

  localparam int MAXHITNBITS      = 4;
  localparam int ROWINDEXBITS_HLM = 10;
  localparam int NCOLS_HCM        = ROWINDEXBITS_HLM + MAXHITNBITS;

  // HCM word layout: {hlm_addr, count}
  localparam int HCM_CNT_LSB      = 0;
  localparam int HCM_ADDR_LSB     = MAXHITNBITS;

  // Width of the emit slot index (0 .. HITSPERROW-1)
  localparam int KBITS            = $clog2(HITSPERROW);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_HNM_REQ  = 4'd1,
    S_HNM_WAIT = 4'd2,
    S_SCAN     = 4'd3,
    S_HCM_REQ  = 4'd4,
    S_HCM_WAIT = 4'd5,
    S_HLM_REQ  = 4'd6,
    S_HLM_WAIT = 4'd7,
    S_EMIT     = 4'd8,
    S_DONE     = 4'd9
  } state_t;

  // Pick one hit info out of an HLM row; slot 0 is the most recent hit.
  function automatic logic [HITINFOBITS-1:0] hit_slot(
    input logic [NCOLS_HLM-1:0] row,
    input logic [KBITS-1:0]     k
  );
    return row[k*HITINFOBITS +: HITINFOBITS];
  endfunction

endpackage

`default_nettype wire

// File: rtl/hit_readout_if.sv
// ============================================================================
//  Module   : hit_readout_if
//  Purpose  : Bundles the three storage-memory read ports (HNM, HCM, HLM) and
//             the valid/ready hit output stream.
//  Ports    : master - readout engine side (drives addresses and stream)
//             slave  - memories / consumer side
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface hit_readout_if;
  import hit_readout_pkg::*;

  logic [ROWINDEXBITS_HNM-1:0] hnmAddr;
  logic [NCOLS_HNM-1:0]        hnmData;
  logic [SSIDBITS-1:0]         hcmAddr;
  logic [NCOLS_HCM-1:0]        hcmData;
  logic [ROWINDEXBITS_HLM-1:0] hlmAddr;
  logic [NCOLS_HLM-1:0]        hlmData;
  logic                        outValid;
  logic                        outReady;
  logic [SSIDBITS-1:0]         outSSID;
  logic [HITINFOBITS-1:0]      outHitInfo;
  logic                        outLast;

  modport master (
    output hnmAddr, input hnmData,
    output hcmAddr, input hcmData,
    output hlmAddr, input hlmData,
    output outValid, input outReady,
    output outSSID, output outHitInfo, output outLast
  );

  modport slave (
    input hnmAddr, output hnmData,
    input hcmAddr, output hcmData,
    input hlmAddr, output hlmData,
    input outValid, output outReady,
    input outSSID, input outHitInfo, input outLast
  );

endinterface

`default_nettype wire

// File: rtl/hit_readout_prienc.sv
// ============================================================================
//  Module   : hit_readout_prienc
//  Purpose  : Combinational lowest-set-bit encoder for one HNM row mask.
//  Ports    : vec_i   - row mask (NCOLS_HNM bits)
//             idx_o   - index of the lowest set bit (0 when none)
//             found_o - 1 when any bit of vec_i is set
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hit_readout_prienc
  import hit_readout_pkg::*;
(
  input  wire logic [NCOLS_HNM-1:0]    vec_i,
  output logic      [COLINDEXBITS-1:0] idx_o,
  output logic                         found_o
);

  // Walk from the top down so the last (lowest) set bit wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = NCOLS_HNM - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = COLINDEXBITS'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hit_readout.sv
// ============================================================================
//  Module   : hit_readout
//  Purpose  : Scans the Hits New Memory bitmap, looks up each flagged SSID in
//             the Hits Count Memory, fetches its Hits List Memory row and
//             streams the stored hit infos oldest first.
//  Ports    : clk, rst          - clock, asynchronous active-high reset
//             startReadout_i    - one-cycle start request
//             busy_o            - readout in progress
//             readoutDone_o     - one-cycle completion pulse
//             ssidCount_o       - SSIDs emitted this readout
//             overflowFlag_o    - sticky: a count exceeded HITSPERROW
//             countError_o      - sticky: flagged SSID had count 0
//             bus               - memory read ports + output stream (master)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hit_readout
  import hit_readout_pkg::*;
(
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          startReadout_i,
  output logic               busy_o,
  output logic               readoutDone_o,
  output logic [SSIDBITS-1:0] ssidCount_o,
  output logic               overflowFlag_o,
  output logic               countError_o,
  hit_readout_if.master      bus
);

  state_t                      state_q;
  logic [ROWINDEXBITS_HNM-1:0] row_q;
  logic [NCOLS_HNM-1:0]        mask_q;
  logic [SSIDBITS-1:0]         ssid_q;
  logic [KBITS-1:0]            k_q;
  logic [NCOLS_HLM-1:0]        hlmrow_q;

  logic [ROWINDEXBITS_HNM-1:0] hnmAddr_q;
  logic [SSIDBITS-1:0]         hcmAddr_q;
  logic [ROWINDEXBITS_HLM-1:0] hlmAddr_q;
  logic                        outValid_q;
  logic [SSIDBITS-1:0]         outSSID_q;
  logic [HITINFOBITS-1:0]      outHitInfo_q;
  logic                        outLast_q;
  logic                        busy_q;
  logic                        readoutDone_q;
  logic [SSIDBITS-1:0]         ssidCount_q;
  logic                        overflow_q;
  logic                        countErr_q;

  logic [COLINDEXBITS-1:0]     col_d;
  logic                        found_d;
  logic [MAXHITNBITS-1:0]      hcmCnt_d;
  logic [ROWINDEXBITS_HLM-1:0] hcmHlmAddr_d;
  logic [MAXHITNBITS-1:0]      clampCnt_d;
  logic [KBITS-1:0]            kLoad_d;
  logic [KBITS-1:0]            kDec_d;

  hit_readout_prienc u_prienc (
    .vec_i   (mask_q),
    .idx_o   (col_d),
    .found_o (found_d)
  );

  always_comb begin
    hcmCnt_d     = bus.hcmData[HCM_CNT_LSB  +: MAXHITNBITS];
    hcmHlmAddr_d = bus.hcmData[HCM_ADDR_LSB +: ROWINDEXBITS_HLM];
    clampCnt_d   = (hcmCnt_d > MAXHITNBITS'(HITSPERROW)) ?
                   MAXHITNBITS'(HITSPERROW) : hcmCnt_d;
    // Only meaningful when the count is non-zero (zero diverts to SCAN).
    kLoad_d      = KBITS'(clampCnt_d - 1'b1);
    kDec_d       = k_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      row_q         <= '0;
      mask_q        <= '0;
      ssid_q        <= '0;
      k_q           <= '0;
      hlmrow_q      <= '0;
      hnmAddr_q     <= '0;
      hcmAddr_q     <= '0;
      hlmAddr_q     <= '0;
      outValid_q    <= 1'b0;
      outSSID_q     <= '0;
      outHitInfo_q  <= '0;
      outLast_q     <= 1'b0;
      busy_q        <= 1'b0;
      readoutDone_q <= 1'b0;
      ssidCount_q   <= '0;
      overflow_q    <= 1'b0;
      countErr_q    <= 1'b0;
    end else begin
      readoutDone_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (startReadout_i) begin
            row_q       <= '0;
            hnmAddr_q   <= '0;
            busy_q      <= 1'b1;
            ssidCount_q <= '0;
            overflow_q  <= 1'b0;
            countErr_q  <= 1'b0;
            state_q     <= S_HNM_REQ;
          end
        end
        S_HNM_REQ:  state_q <= S_HNM_WAIT;
        S_HNM_WAIT: begin
          mask_q  <= bus.hnmData;
          state_q <= S_SCAN;
        end
        S_SCAN: begin
          if (found_d) begin
            ssid_q    <= {row_q, col_d};
            hcmAddr_q <= {row_q, col_d};
            mask_q    <= mask_q & ~(NCOLS_HNM'(1) << col_d);
            state_q   <= S_HCM_REQ;
          end else if (&row_q) begin
            state_q <= S_DONE;
          end else begin
            row_q     <= row_q + 1'b1;
            hnmAddr_q <= row_q + 1'b1;
            state_q   <= S_HNM_REQ;
          end
        end
        S_HCM_REQ:  state_q <= S_HCM_WAIT;
        S_HCM_WAIT: begin
          if (hcmCnt_d == '0) begin
            countErr_q <= 1'b1;
            state_q    <= S_SCAN;
          end else begin
            if (hcmCnt_d > MAXHITNBITS'(HITSPERROW)) overflow_q <= 1'b1;
            k_q       <= kLoad_d;
            hlmAddr_q <= hcmHlmAddr_d;
            state_q   <= S_HLM_REQ;
          end
        end
        S_HLM_REQ:  state_q <= S_HLM_WAIT;
        S_HLM_WAIT: begin
          // Present the first (oldest) word straight from the bus so it is
          // valid on the first EMIT cycle.
          hlmrow_q     <= bus.hlmData;
          outValid_q   <= 1'b1;
          outSSID_q    <= ssid_q;
          outHitInfo_q <= hit_slot(bus.hlmData, k_q);
          outLast_q    <= (k_q == '0);
          state_q      <= S_EMIT;
        end
        S_EMIT: begin
          if (bus.outReady) begin
            if (k_q == '0) begin
              outValid_q  <= 1'b0;
              outLast_q   <= 1'b0;
              ssidCount_q <= ssidCount_q + 1'b1;
              state_q     <= S_SCAN;
            end else begin
              k_q          <= kDec_d;
              outHitInfo_q <= hit_slot(hlmrow_q, kDec_d);
              outLast_q    <= (kDec_d == '0);
            end
          end
        end
        S_DONE: begin
          readoutDone_q <= 1'b1;
          busy_q        <= 1'b0;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.hnmAddr    = hnmAddr_q;
  assign bus.hcmAddr    = hcmAddr_q;
  assign bus.hlmAddr    = hlmAddr_q;
  assign bus.outValid   = outValid_q;
  assign bus.outSSID    = outSSID_q;
  assign bus.outHitInfo = outHitInfo_q;
  assign bus.outLast    = outLast_q;
  assign busy_o         = busy_q;
  assign readoutDone_o  = readoutDone_q;
  assign ssidCount_o    = ssidCount_q;
  assign overflowFlag_o = overflow_q;
  assign countError_o   = countErr_q;

endmodule

`default_nettype wire
